// File: rtl/sync_ff.sv
// Multi-flop synchronizer that brings an asynchronous level into the i_Clk domain.
// Reusable for any single-bit asynchronous input; o_Q is the last flop in the chain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_D,
  output logic o_Q
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_ff: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_D};
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_Q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Debounces a bouncing mechanical switch: a new synchronized level must hold for
// DEBOUNCE_LIMIT consecutive clocks before o_Switch follows it; press/release pulses mark acceptance.
module switch_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release
);

  if (DEBOUNCE_LIMIT < 2 || SYNC_STAGES < 2) begin : g_bad_params
    $error("switch_debounce: DEBOUNCE_LIMIT and SYNC_STAGES must both be at least 2");
  end

  localparam int              CNT_W   = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  logic             s_sync;
  state_e           state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_q, sw_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_D  (i_Switch),
    .o_Q  (s_sync)
  );

  // The settle state is implied by the synchronized level disagreeing with the accepted one.
  always_comb begin
    state = (s_sync == sw_q) ? ST_STABLE : ST_SETTLING;
  end

  always_comb begin
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state)
      ST_STABLE: begin
        cnt_d = '0;
      end
      ST_SETTLING: begin
        if (cnt_q == CNT_MAX) begin
          // Pulses are registered with the new level so they coincide with its first cycle.
          sw_d    = s_sync;
          cnt_d   = '0;
          press_d = s_sync;
          rel_d   = ~s_sync;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign o_Switch  = sw_q;
  assign o_Press   = press_q;
  assign o_Release = rel_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: directed scenarios plus random bouncing,
// checked against a sliding-window reference model of the debounce rule.
module tb_switch_debounce;

  localparam int LIM  = 4;
  localparam int SYNC = 2;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  logic i_Switch = 1'b0;
  logic o_Switch, o_Press, o_Release;

  int total = 0;
  int bad   = 0;

  logic [2:0] expq[$];

  // Reference model state
  bit sync_m[SYNC];
  bit win_m[$];
  bit out_m;

  switch_debounce #(
    .DEBOUNCE_LIMIT(LIM),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Switch (i_Switch),
    .o_Switch (o_Switch),
    .o_Press  (o_Press),
    .o_Release(o_Release)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  // Model: the accepted level flips when the last LIM synchronized samples all disagree with it.
  function automatic logic [2:0] model_step(input bit rst, input bit sw);
    bit s, all_diff, press, rel;
    press = 1'b0;
    rel   = 1'b0;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) sync_m[i] = 1'b0;
      win_m.delete();
      for (int i = 0; i < LIM; i++) win_m.push_back(1'b0);
      out_m = 1'b0;
    end else begin
      s = sync_m[SYNC-1];
      win_m.push_back(s);
      void'(win_m.pop_front());
      all_diff = 1'b1;
      foreach (win_m[i]) if (win_m[i] == out_m) all_diff = 1'b0;
      if (all_diff) begin
        out_m = ~out_m;
        press = out_m;
        rel   = ~out_m;
      end
      for (int i = SYNC - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
      sync_m[0] = sw;
    end
    return {out_m, press, rel};
  endfunction

  task automatic drive(input bit sw, input bit rst);
    i_Switch = sw;
    i_Rst    = rst;
    @(posedge i_Clk);
    expq.push_back(model_step(rst, sw));
    @(negedge i_Clk);
  endtask

  task automatic hold(input bit sw, input int n);
    for (int i = 0; i < n; i++) drive(sw, 1'b0);
  endtask

  // Drive sw until o_Switch reaches sw; check the number of clocks taken.
  task automatic check_latency(input string name, input bit sw, input int want);
    int n;
    n = 0;
    while (o_Switch != sw && n < 20) begin
      drive(sw, 1'b0);
      n++;
    end
    total++;
    if (n != want) begin
      bad++;
      $display("FAIL %s: latency got %0d clocks, required %0d", name, n, want);
    end
  endtask

  // Monitor: every clock presents an output triple; pop and compare.
  initial begin
    logic [2:0] exp_v, got_v;
    forever begin
      @(negedge i_Clk);
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        got_v = {o_Switch, o_Press, o_Release};
        total++;
        if (got_v !== exp_v || (o_Press && o_Release)) begin
          bad++;
          $display("FAIL outputs @%0t: got sw/press/rel=%b, required %b", $time, got_v, exp_v);
        end
      end
    end
  end

  initial begin
    int run;
    bit lvl;
    out_m = 1'b0;
    for (int i = 0; i < SYNC; i++) sync_m[i] = 1'b0;
    for (int i = 0; i < LIM; i++) win_m.push_back(1'b0);
    @(negedge i_Clk);

    // Reset held with the switch high, then release: press accepted after full latency.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
    check_latency("reset_release_press", 1'b1, SYNC + LIM);
    hold(1'b1, 4);

    // Clean release and clean press.
    check_latency("clean_release", 1'b0, SYNC + LIM);
    hold(1'b0, 4);
    check_latency("clean_press", 1'b1, SYNC + LIM);
    hold(1'b1, 4);

    // Short glitch low must be ignored.
    hold(1'b0, 3);
    hold(1'b1, 10);

    check_latency("release", 1'b0, SYNC + LIM);
    hold(1'b0, 4);

    // Bounce then settle high.
    drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    check_latency("bounce_press", 1'b1, SYNC + LIM - 1);
    hold(1'b1, 4);
    hold(1'b0, 12);

    // Reset for one clock while the counter is at 2; count must restart.
    hold(1'b1, 4);
    drive(1'b1, 1'b1);
    check_latency("reset_mid_settle", 1'b1, SYNC + LIM);
    hold(1'b1, 4);

    // Random bouncing with occasional resets.
    lvl = 1'b0;
    for (int k = 0; k < 600; k++) begin
      run = $urandom_range(1, 2 * LIM + 3);
      lvl = ~lvl;
      for (int j = 0; j < run; j++) drive(lvl, ($urandom_range(0, 199) == 0));
    end
    hold(lvl, 2 * (SYNC + LIM));

    @(negedge i_Clk);
    @(negedge i_Clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter DEBOUNCE_LIMIT, default 250000, is the number of consecutive clocks a new synchronized level must hold before acceptance (10 ms at 25 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth in flops.
REQ-003 Port i_Clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port i_Switch, input, 1 bit: raw, asynchronous, bouncing switch level.
REQ-006 Port o_Switch, output, 1 bit: debounced switch level, registered.
REQ-007 Port o_Press, output, 1 bit: single-cycle pulse on an accepted 0->1 transition of o_Switch.
REQ-008 Port o_Release, output, 1 bit: single-cycle pulse on an accepted 1->0 transition of o_Switch.

Function
REQ-009 i_Switch SHALL pass through a SYNC_STAGES-deep flop chain; the last stage, s_sync, is the only internal use of the input.
REQ-010 The block SHALL hold a counter of width clog2(DEBOUNCE_LIMIT) that is unsigned and never wraps.
REQ-011 States: STABLE when s_sync == o_Switch, counter held at 0; SETTLING when s_sync != o_Switch.
REQ-012 In SETTLING with counter < DEBOUNCE_LIMIT-1, the counter SHALL increment by 1 per clock.
REQ-013 In SETTLING with counter == DEBOUNCE_LIMIT-1:
- o_Switch <= s_sync on the next edge;
- counter <= 0;
- return to STABLE.
REQ-014 Any cycle in SETTLING where s_sync returns to o_Switch SHALL clear the counter to 0 and return to STABLE; there is no partial credit for a glitch.
REQ-015 Latency: o_Switch changes exactly DEBOUNCE_LIMIT clocks after the first cycle s_sync differs, provided s_sync holds constant throughout; total latency from an i_Switch edge is SYNC_STAGES + DEBOUNCE_LIMIT clocks.
REQ-016 o_Press SHALL be 1 for exactly the first clock in which o_Switch reads 1 after reading 0; otherwise it is 0.
REQ-017 o_Release SHALL be 1 for exactly the first clock in which o_Switch reads 0 after reading 1; otherwise it is 0.
REQ-018 o_Press and o_Release SHALL never be asserted in the same cycle.
REQ-019 Back-to-back accepted transitions SHALL be separated by at least DEBOUNCE_LIMIT clocks; pulses from them SHALL never merge.
REQ-020 DEBOUNCE_LIMIT < 2 or SYNC_STAGES < 2 SHALL be rejected at elaboration.

Reset
REQ-021 While i_Rst = 1 at a clock edge, the following SHALL load 0: synchronizer flops, counter, o_Switch, o_Press, o_Release.
REQ-022 Reset asserted mid-SETTLING SHALL discard the count; after release, a held-high i_Switch needs the full SYNC_STAGES + DEBOUNCE_LIMIT clocks before o_Switch = 1.
REQ-023 A level already 1 at reset release SHALL produce an o_Press pulse when it is accepted.

Structure
REQ-024 No shared package SHALL be used; all constants are local parameters.
REQ-025 The synchronizer SHALL be a sub-module sync_ff (parameter SYNC_STAGES, ports i_Clk, i_Rst, i_D, o_Q) so that it is reusable for other switches.
REQ-026 switch_debounce SHALL sit directly upstream of the edge-toggle LED logic; o_Switch and o_Release replace its raw switch input and its edge detector.

Verification (DEBOUNCE_LIMIT=4, SYNC_STAGES=2)
REQ-027 Reset check: hold i_Rst=1 for 3 clocks with i_Switch=1 -> all outputs stay 0; release reset -> o_Switch=1 and a single o_Press pulse appear 6 clocks after release.
REQ-028 Clean press: i_Switch 0->1 held -> o_Switch rises exactly 6 clocks later with o_Press=1 for 1 cycle; o_Release stays 0.
REQ-029 Bounce: i_Switch toggles 1,0,1,0,1 at 1-clock intervals then holds 1 -> o_Switch rises 6 clocks after the final 0->1 with no extra pulses.
REQ-030 Short glitch: with o_Switch=1, i_Switch drops to 0 for 3 clocks -> o_Switch stays 1 and o_Release stays 0.
REQ-031 Release: with o_Switch=1, i_Switch 1->0 held -> o_Switch falls 6 clocks later with o_Release=1 for 1 cycle.
REQ-032 Reset mid-SETTLING: assert i_Rst for 1 clock at counter=2 -> counter and o_Switch are 0 and the full 6-clock latency restarts.
